// File: rtl/data_mem_unit.sv
// data_mem_unit: word-organised data memory for riscv_core.
// Features: byte-masked writes, a registered read with a valid strobe, a
// read-first debug port, a sticky out-of-range flag and a tracker of the
// range of addresses written.
// Optional feature macro: DMEM_RANGE_TRACK_EN
//   defined   -> min/max written-address tracker registers are built.
//   undefined -> tracker outputs are tied to cover the whole memory.
module data_mem_unit #(
  parameter int DEPTH = 512,
  parameter int AW    = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    mask_i,
  output logic [31:0]   rdata_o,
  output logic          rvalid_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [31:0]   dbg_data_o,
  input  logic          clear_i,
  output logic [AW-1:0] min_addr_o,
  output logic [AW-1:0] max_addr_o,
  output logic          range_valid_o,
  output logic          err_o
);

  // Highest word-aligned byte address inside the array.
  localparam logic [AW-1:0] TOP_ADDR = AW'(DEPTH * 4 - 4);

  // Storage is deliberately not reset so contents survive rst_i.
  logic [31:0] mem_q [DEPTH];

  logic [IDX_W-1:0] idx_s;
  logic [IDX_W-1:0] dbg_idx_s;
  logic             oor_s;
  logic             dbg_oor_s;
  logic             rd_s;
  logic             wr_s;
  logic             unused_addr_lsb_s;

  logic [31:0] rdata_d, rdata_q;
  logic        rvalid_d, rvalid_q;
  logic [31:0] dbg_data_d, dbg_data_q;
  logic        err_d, err_q;

  // Any address bit above the index field set means addr >= DEPTH*4.
  assign idx_s     = addr_i[IDX_W+1:2];
  assign dbg_idx_s = dbg_addr_i[IDX_W+1:2];
  assign oor_s     = |addr_i[AW-1:IDX_W+2];
  assign dbg_oor_s = |dbg_addr_i[AW-1:IDX_W+2];
  assign rd_s      = req_i & ~we_i;
  // Out-of-range and all-zero-mask writes leave the array untouched.
  assign wr_s      = req_i & we_i & ~oor_s & (|mask_i);

  // Byte offset bits carry no meaning for a word memory.
  assign unused_addr_lsb_s = ^{addr_i[1:0], dbg_addr_i[1:0]};

  // Byte-masked array write.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_s && mask_i[b]) begin
        mem_q[idx_s][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Next-state for read data, valid strobe, debug data and sticky error.
  always_comb begin
    rvalid_d   = rd_s;
    rdata_d    = rdata_q;
    if (rd_s) begin
      rdata_d = oor_s ? 32'h0000_0000 : mem_q[idx_s];
    end else begin
      rdata_d = rdata_q;
    end
    // Sampled before this edge's write lands, giving read-first behaviour.
    dbg_data_d = dbg_oor_s ? 32'h0000_0000 : mem_q[dbg_idx_s];
    // Clear first, then let a same-cycle out-of-range access set it again.
    err_d = clear_i ? 1'b0 : err_q;
    if (req_i && oor_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // Output registers; reset drops any in-flight read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q    <= 32'h0000_0000;
      rvalid_q   <= 1'b0;
      dbg_data_q <= 32'h0000_0000;
      err_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      dbg_data_q <= dbg_data_d;
      err_q      <= err_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign dbg_data_o = dbg_data_q;
  assign err_o      = err_q;

`ifdef DMEM_RANGE_TRACK_EN
  logic [AW-1:0] min_addr_d, min_addr_q;
  logic [AW-1:0] max_addr_d, max_addr_q;
  logic          range_valid_d, range_valid_q;
  logic [AW-1:0] wr_addr_s;
  logic [AW-1:0] base_min_s;
  logic [AW-1:0] base_max_s;
  logic          base_valid_s;

  assign wr_addr_s = {addr_i[AW-1:2], 2'b00};

  // Tracker next-state: clear to reset values, then fold in this write.
  always_comb begin
    if (clear_i) begin
      base_min_s   = {AW{1'b1}};
      base_max_s   = {AW{1'b0}};
      base_valid_s = 1'b0;
    end else begin
      base_min_s   = min_addr_q;
      base_max_s   = max_addr_q;
      base_valid_s = range_valid_q;
    end
    min_addr_d    = base_min_s;
    max_addr_d    = base_max_s;
    range_valid_d = base_valid_s;
    if (wr_s) begin
      min_addr_d    = (wr_addr_s < base_min_s) ? wr_addr_s : base_min_s;
      max_addr_d    = (wr_addr_s > base_max_s) ? wr_addr_s : base_max_s;
      range_valid_d = 1'b1;
    end else begin
      range_valid_d = base_valid_s;
    end
  end

  // Tracker registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      min_addr_q    <= {AW{1'b1}};
      max_addr_q    <= {AW{1'b0}};
      range_valid_q <= 1'b0;
    end else begin
      min_addr_q    <= min_addr_d;
      max_addr_q    <= max_addr_d;
      range_valid_q <= range_valid_d;
    end
  end

  assign min_addr_o    = min_addr_q;
  assign max_addr_o    = max_addr_q;
  assign range_valid_o = range_valid_q;
`else
  // Without a tracker the dump window is the whole array.
  assign min_addr_o    = {AW{1'b0}};
  assign max_addr_o    = TOP_ADDR;
  assign range_valid_o = 1'b1;
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit with a read-data scoreboard.
// Honours DMEM_RANGE_TRACK_EN to choose tracker expectations.
module tb_data_mem_unit;

  localparam int DEPTH = 512;
  localparam int AW    = 32;
  localparam logic [31:0] LIMIT = 32'h0000_0800;

  logic          clk;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    mask;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data;
  logic          clear;
  logic [AW-1:0] min_addr;
  logic [AW-1:0] max_addr;
  logic          range_valid;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  logic        exp_err;
  logic [31:0] exp_min;
  logic [31:0] exp_max;
  logic        exp_rv;

  data_mem_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .we_i          (we),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .mask_i        (mask),
    .rdata_o       (rdata),
    .rvalid_o      (rvalid),
    .dbg_addr_i    (dbg_addr),
    .dbg_data_o    (dbg_data),
    .clear_i       (clear),
    .min_addr_o    (min_addr),
    .max_addr_o    (max_addr),
    .range_valid_o (range_valid),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tracker(input string tag);
`ifdef DMEM_RANGE_TRACK_EN
    chk({tag, "_min"}, min_addr, exp_min);
    chk({tag, "_max"}, max_addr, exp_max);
    chk({tag, "_rv"}, {31'd0, range_valid}, {31'd0, exp_rv});
`else
    chk({tag, "_min"}, min_addr, 32'h0000_0000);
    chk({tag, "_max"}, max_addr, 32'h0000_07FC);
    chk({tag, "_rv"}, {31'd0, range_valid}, 32'd1);
`endif
  endtask

  // Advance one edge and check the read side against the scoreboard.
  task automatic tick(input bit rd);
    @(posedge clk);
    #1;
    if (rd) begin
      chk("rvalid_pulse", {31'd0, rvalid}, 32'd1);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty observed 0 entries expected 1");
      end
      if (exp_q.size() != 0) begin
        last_rd = exp_q.pop_front();
        chk("rdata", rdata, last_rd);
      end
    end else begin
      chk("rvalid_idle", {31'd0, rvalid}, 32'd0);
      chk("rdata_hold", rdata, last_rd);
    end
  endtask

  task automatic access(input bit rq, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input bit clr);
    logic [31:0] e_dbg;
    bit          oor;
    int          ix;
    req = rq; we = w; addr = a; wdata = d; mask = m; clear = clr;
    oor = (a >= LIMIT);
    ix  = int'(a[10:2]);
    e_dbg = (dbg_addr >= LIMIT) ? 32'h0 : model[int'(dbg_addr[10:2])];
    if (clr) begin
      exp_err = 1'b0;
      exp_min = 32'hFFFF_FFFF;
      exp_max = 32'h0;
      exp_rv  = 1'b0;
    end
    if (rq && oor) exp_err = 1'b1;
    if (rq && !w) exp_q.push_back(oor ? 32'h0 : model[ix]);
    if (rq && w && !oor && m != 4'h0) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) model[ix][8*b +: 8] = d[8*b +: 8];
      end
      if ({a[31:2], 2'b00} < exp_min) exp_min = {a[31:2], 2'b00};
      if ({a[31:2], 2'b00} > exp_max) exp_max = {a[31:2], 2'b00};
      exp_rv = 1'b1;
    end
    tick(rq && !w);
    chk("dbg_data", dbg_data, e_dbg);
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk_tracker("trk");
    req = 1'b0; we = 1'b0; clear = 1'b0; mask = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'hxxxx_xxxx;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    mask = 4'h0; dbg_addr = 32'h0; clear = 1'b0;
    last_rd = 32'h0; exp_err = 1'b0;
    exp_min = 32'hFFFF_FFFF; exp_max = 32'h0; exp_rv = 1'b0;

    // Reset state
    #12;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_dbg", dbg_data, 32'h0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk_tracker("rst");
    @(negedge clk);
    rst = 1'b0;

    // Known background, then full write and read-back
    access(1, 1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0);
    access(1, 1, 32'h0000_0020, 32'h0000_0000, 4'hF, 0);
    access(1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0);
    access(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0);
    access(0, 0, 32'h0, 32'h0, 4'h0, 0);

    // Byte-masked merges
    access(1, 1, 32'h0000_0100, 32'h0000_00AA, 4'b0001, 0);
    access(1, 1, 32'h0000_0102, 32'h5500_0000, 4'b1000, 0);
    access(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0);

    // Zero mask is a no-op and not tracked
    access(1, 1, 32'h0000_03F0, 32'hFFFF_FFFF, 4'h0, 0);
    access(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0);

    // Tracker: clear, then a spread of writes, then clear with a write
    access(0, 0, 32'h0, 32'h0, 4'h0, 1);
    access(1, 1, 32'h0000_0040, 32'h1111_1111, 4'hF, 0);
    access(1, 1, 32'h0000_01FC, 32'h2222_2222, 4'hF, 0);
    access(1, 1, 32'h0000_0010, 32'h3333_3333, 4'hF, 0);
    access(1, 1, 32'h0000_0083, 32'h4444_4444, 4'hF, 1);

    // Out-of-range write: no aliasing into word 0, sticky error
    access(1, 1, 32'h0000_0800, 32'hFFFF_FFFF, 4'hF, 0);
    access(0, 0, 32'h0, 32'h0, 4'h0, 0);
    access(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0);
    access(1, 0, 32'h0000_0800, 32'h0, 4'h0, 0);
    access(1, 0, 32'h0000_01FC, 32'h0, 4'h0, 0);
    access(0, 0, 32'h0, 32'h0, 4'h0, 1);
    // Clear coinciding with an out-of-range read leaves the error set
    access(1, 0, 32'h8000_0000, 32'h0, 4'h0, 1);
    access(0, 0, 32'h0, 32'h0, 4'h0, 1);

    // Debug port is read-first
    dbg_addr = 32'h0000_0020;
    access(1, 1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0);
    access(0, 0, 32'h0, 32'h0, 4'h0, 0);
    dbg_addr = 32'h0000_0900;
    access(0, 0, 32'h0, 32'h0, 4'h0, 0);
    dbg_addr = 32'h0000_0100;

    // Reset during an active read: valid drops at once, contents survive
    access(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0);
    req = 1'b1; we = 1'b0; addr = 32'h0000_0100;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_err", {31'd0, err}, 32'd0);
    req = 1'b0;
    last_rd = 32'h0; exp_err = 1'b0;
    exp_min = 32'hFFFF_FFFF; exp_max = 32'h0; exp_rv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0);
    access(1, 0, 32'h0000_0020, 32'h0, 4'h0, 0);
    access(0, 0, 32'h0, 32'h0, 4'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised, synthesizable data memory that replaces the behavioural word-array data memory used around `riscv_core`. It adds:
- byte-masked writes;
- a registered read with a valid strobe;
- an independent debug read port for memory dumps;
- out-of-range detection;
- a written-address range tracker that feeds the core's min/max data address reporting.

It sits between the core's data memory interface and the debug/dump logic.

## Interface
Parameters:
- `DEPTH`, 512 — number of 32-bit words; power of two, ≥ 4.
- `AW`, 32 — byte address width.
- `IDX_W`, $clog2(DEPTH) — word index width (derived, do not override).

Ports:
- `clk_i` in 1 — single clock.
- `rst_i` in 1 — reset, asynchronous, active-high.
- `req_i` in 1 — access request this cycle.
- `we_i` in 1 — 1 = write, 0 = read (qualified by `req_i`).
- `addr_i` in AW — byte address; bits [1:0] ignored.
- `wdata_i` in 32 — write data.
- `mask_i` in 4 — byte enables; bit n writes `wdata_i[8n+7:8n]`.
- `rdata_o` out 32 — read data.
- `rvalid_o` out 1 — `rdata_o` valid, one-cycle pulse.
- `dbg_addr_i` in AW — debug read byte address.
- `dbg_data_o` out 32 — debug read data (registered).
- `clear_i` in 1 — clears the range tracker and `err_o`.
- `min_addr_o` out AW — lowest word-aligned byte address written since clear.
- `max_addr_o` out AW — highest word-aligned byte address written since clear.
- `range_valid_o` out 1 — at least one write recorded since clear.
- `err_o` out 1 — sticky out-of-range access flag.

## Operation
- Word index is `addr_i[IDX_W+1:2]`.
- An access is out-of-range if `addr_i >= DEPTH*4`. Out-of-range accesses:
  - do not modify the array;
  - return 0 on read, with `rvalid_o` still pulsing;
  - set `err_o` on the following edge.
- Write (`req_i & we_i`): only bytes with `mask_i` set are updated. `mask_i` = 0 is a no-op and is not recorded by the tracker.
- Read (`req_i & ~we_i`): the full word is captured into `rdata_o`.
- The array is not reset; it powers up as X in simulation.
- Debug port: each cycle `dbg_data_o` <= word at `dbg_addr_i`, or 0 if that address is out-of-range. The debug port is read-only and independent of the main port.
- Range tracker, per recorded in-range write of address `a = {addr_i[AW-1:2],2'b00}`:
  - `min_addr_o` <= min(`min_addr_o`, a);
  - `max_addr_o` <= max(`max_addr_o`, a);
  - `range_valid_o` <= 1.
- `clear_i` resets the tracker to its reset values and clears `err_o`.
- If `clear_i` coincides with an access, the clear is applied first and that same-cycle access is then recorded. Result: tracker = that write only; `err_o` = 1 if that access is out-of-range.

## Timing
- Reset values (asserted asynchronously):
  - `rdata_o` = 0, `rvalid_o` = 0, `dbg_data_o` = 0;
  - `min_addr_o` = all ones, `max_addr_o` = 0;
  - `range_valid_o` = 0, `err_o` = 0.
- Read latency is 1: request at edge N gives `rdata_o` valid and `rvalid_o` = 1 after edge N+1.
  - `rvalid_o` is low in every cycle without a read.
  - `rdata_o` holds its last value when no read is issued.
- Back-to-back reads every cycle are supported; throughput is one access per cycle. No stall or backpressure.
- A write committed at edge N is visible to a read issued in cycle N+1.
- Debug port is read-first: a same-cycle write to the same word returns old data; new data appears one cycle later.
- Tracker and `err_o` update on the same edge as the write or access.
- Reset mid-operation:
  - an in-flight read is dropped (`rvalid_o` forced 0);
  - array contents are retained.

## Configuration
- `DMEM_RANGE_TRACK_EN` defined: the range tracker is implemented as described above.
- `DMEM_RANGE_TRACK_EN` undefined: no tracker registers exist. Outputs are tied constant:
  - `min_addr_o` = 0;
  - `max_addr_o` = `DEPTH*4-4`;
  - `range_valid_o` = 1.

  Dump logic therefore covers the whole memory. `clear_i` then only clears `err_o`.

## Test plan
- Write 0xDEADBEEF to 0x100 with mask 4'hF, then read 0x100 next cycle -> `rdata_o` = 0xDEADBEEF with `rvalid_o` pulsing exactly one cycle, 1 cycle after the read request.
- Over 0xDEADBEEF at 0x100, write 0x000000AA with mask 4'b0001, then 0x55000000 with mask 4'b1000 -> read 0x100 returns 0x55ADBEAA.
- Writes to 0x40, 0x1FC, 0x10 (tracker enabled) -> `min_addr_o` = 0x10, `max_addr_o` = 0x1FC, `range_valid_o` = 1. Then `clear_i` together with a write to 0x80 -> min = max = 0x80.
- Write to 0x800 (DEPTH = 512) -> array unchanged, `err_o` = 1 and sticky. Read of 0x800 returns 0. `clear_i` returns `err_o` to 0.
- Same cycle: write 0x12345678 to 0x20 and debug read of 0x20 (previously 0x0) -> `dbg_data_o` = 0 on the next cycle, then 0x12345678 the cycle after.
- Assert `rst_i` mid-read -> `rvalid_o` = 0 immediately. After release, reading the previously written word returns its retained value.
